// File: rtl/eth_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_csr_pkg
// Purpose  : Shared types and constants for the Ethernet CSR mailbox
//            sequencer. These include the FSM state type, the mailbox command
//            word layout, the AFU CSR offsets of the three mailbox registers,
//            and a helper that packs a command into the 32-bit mailbox word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package eth_csr_pkg;

  // Mailbox sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } t_mbox_state;

  // Bit positions inside the command/address mailbox word
  localparam int ETH_CMD_WR_BIT  = 16;
  localparam int ETH_CMD_RD_BIT  = 17;
  localparam int ETH_ADDR_LSB    = 0;
  localparam int ETH_MBOX_ADDR_W = 16;

  // Command fields as they appear in bits [17:0] of the mailbox word
  typedef struct packed {
    logic                       rd;
    logic                       wr;
    logic [ETH_MBOX_ADDR_W-1:0] addr;
  } t_eth_mbox_cmd;

  // AFU CSR offsets of the mailbox registers
  localparam logic [15:0] ETH_CSR_CTRL_ADDR_OFS = 16'h0030;
  localparam logic [15:0] ETH_CSR_WR_DATA_OFS   = 16'h0038;
  localparam logic [15:0] ETH_CSR_RD_DATA_OFS   = 16'h0040;

  // Pack a command into the 32-bit mailbox word; unused upper bits are zero.
  function automatic logic [31:0] eth_mbox_word(input t_eth_mbox_cmd cmd);
    logic [31:0] word;
    word                                      = '0;
    word[ETH_CMD_RD_BIT]                      = cmd.rd;
    word[ETH_CMD_WR_BIT]                      = cmd.wr;
    word[ETH_ADDR_LSB +: ETH_MBOX_ADDR_W]     = cmd.addr;
    return word;
  endfunction

endpackage : eth_csr_pkg
`default_nettype wire

// File: rtl/eth_csr_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_csr_rr_arb
// Purpose  : Combinational round-robin pick. Returns the index of the first
//            set request bit at or after ptr, wrapping past NUM_REQ-1 back
//            to 0.
// Ports    : req       - request vector, one bit per requester
//            ptr       - index holding the highest priority this cycle
//            grant     - selected requester index (0 when nothing is set)
//            any_valid - at least one request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module eth_csr_rr_arb
  import eth_csr_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_valid
);

  // Walk the offsets from furthest to nearest so the nearest set bit
  // relative to ptr is the last one written and therefore wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant     = IDX_W'((int'(ptr) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

endmodule : eth_csr_rr_arb
`default_nettype wire

// File: rtl/eth_csr_mbox_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_csr_mbox_arb
// Purpose  : Shares the Ethernet CSR mailbox between NUM_REQ requesters.
//            It grants one request at a time in round-robin order, holds the
//            mailbox command bit for CMD_HOLD cycles, and then waits RD_LAT
//            cycles. After that it samples read data and returns a one-cycle
//            completion pulse to the owning requester.
// Ports    : clk, pck_cp2af_softReset_T1 (async, active-high)
//            rq_valid/rq_ready/rq_write/rq_addr/rq_wdata - request side
//            rsp_valid/rsp_rdata                         - completion side
//            busy                                        - transaction active
//            eth_ctrl_addr/eth_wr_data/eth_rd_data       - mailbox words
// Revision : 1.0 - initial release
// ============================================================================
module eth_csr_mbox_arb
  import eth_csr_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CMD_HOLD = 4,
  parameter int RD_LAT   = 8,
  parameter int ADDR_W   = 16
) (
  input  logic                      clk,
  input  logic                      pck_cp2af_softReset_T1,
  input  logic [NUM_REQ-1:0]        rq_valid,
  output logic [NUM_REQ-1:0]        rq_ready,
  input  logic [NUM_REQ-1:0]        rq_write,
  input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
  input  logic [NUM_REQ*32-1:0]     rq_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      busy,
  output logic [31:0]               eth_ctrl_addr,
  output logic [31:0]               eth_wr_data,
  input  logic [31:0]               eth_rd_data
);

  localparam int CNT_MAX = (CMD_HOLD > RD_LAT) ? CMD_HOLD : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Each phase counter is loaded with (length-1) and the phase ends on the
  // cycle it reads zero, so a length of 1 means a single cycle.
  localparam logic [CNT_W-1:0] CMD_LOAD  = CNT_W'(CMD_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  t_mbox_state        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic               owner_wr, owner_wr_nxt;
  logic [IDX_W-1:0]   grant;
  logic               any_valid;
  logic [NUM_REQ-1:0] accept_vec;
  logic [NUM_REQ-1:0] rsp_valid_nxt;
  logic [31:0]        rsp_rdata_nxt;
  logic               busy_nxt;
  logic [31:0]        ctrl_nxt;
  logic [31:0]        wr_data_nxt;
  t_eth_mbox_cmd      cmd;

  eth_csr_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req       (rq_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // The accept pulse is combinational so a requester sees it in the cycle
  // its request is latched. It is masked while reset is held, because the
  // FSM already reads IDLE during reset.
  assign rq_ready = accept_vec & {NUM_REQ{~pck_cp2af_softReset_T1}};

  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ptr           <= '0;
      owner         <= '0;
      owner_wr      <= 1'b0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      busy          <= 1'b0;
      eth_ctrl_addr <= '0;
      eth_wr_data   <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      ptr           <= ptr_nxt;
      owner         <= owner_nxt;
      owner_wr      <= owner_wr_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_rdata     <= rsp_rdata_nxt;
      busy          <= busy_nxt;
      eth_ctrl_addr <= ctrl_nxt;
      eth_wr_data   <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    owner_wr_nxt  = owner_wr;
    accept_vec    = '0;
    rsp_valid_nxt = '0;
    rsp_rdata_nxt = rsp_rdata;
    busy_nxt      = busy;
    ctrl_nxt      = eth_ctrl_addr;
    wr_data_nxt   = eth_wr_data;
    cmd           = '0;

    unique case (state)
      ST_IDLE: begin
        if (any_valid) begin
          accept_vec[grant] = 1'b1;
          owner_nxt         = grant;
          owner_wr_nxt      = rq_write[grant];
          cmd.rd            = ~rq_write[grant];
          cmd.wr            = rq_write[grant];
          cmd.addr          = ETH_MBOX_ADDR_W'(rq_addr[int'(grant)*ADDR_W +: ADDR_W]);
          ctrl_nxt          = eth_mbox_word(cmd);
          // A read leaves the write-data word as it was.
          if (rq_write[grant]) begin
            wr_data_nxt = rq_wdata[int'(grant)*32 +: 32];
          end
          ptr_nxt   = IDX_W'((int'(grant) + 1) % NUM_REQ);
          cnt_nxt   = CMD_LOAD;
          busy_nxt  = 1'b1;
          state_nxt = ST_CMD;
        end
      end

      ST_CMD: begin
        if (cnt == '0) begin
          // Drop both command bits and keep the address, which gives the
          // sync stage a clean deassert edge.
          ctrl_nxt[ETH_CMD_RD_BIT] = 1'b0;
          ctrl_nxt[ETH_CMD_WR_BIT] = 1'b0;
          cnt_nxt                  = WAIT_LOAD;
          state_nxt                = ST_WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt == '0) begin
          rsp_valid_nxt[owner] = 1'b1;
          rsp_rdata_nxt        = owner_wr ? 32'h0 : eth_rd_data;
          state_nxt            = ST_RSP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_RSP: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : eth_csr_mbox_arb
`default_nettype wire
